// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Counter must hold WIDTH-1 for any WIDTH >= 2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        // Sign bit of the widened difference tells whether the divisor fits.
        if (trial[WIDTH+1]) begin
            rem_next = shifted[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/sequential_div.sv
// Multi-cycle signed divider: restoring division on magnitudes, sign fixup at the end.
//   state | meaning
//   IDLE  | waiting for start; results held
//   ITER  | one quotient bit per cycle, WIDTH cycles
//   FIX   | apply signs (or divide-by-zero values), pulse done
module sequential_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q        (q_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_next   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        b_zero_d = b_zero_q;
        quot_d   = quot_q;
        remo_d   = remo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
                    sign_r_d = A[WIDTH-1];
                    q_d      = A[WIDTH-1] ? -A : A;
                    dvs_d    = B[WIDTH-1] ? -B : B;
                    rem_d    = '0;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    busy_d   = 1'b1;
                    b_zero_d = (B == '0);
                    state_d  = (B == '0) ? FIX : ITER;
                end
            end
            ITER: begin
                q_d   = step_q;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (b_zero_q) begin
                    // q still holds |A|; re-applying the dividend sign restores A.
                    quot_d = '1;
                    remo_d = sign_r_q ? -q_q : q_q;
                    dz_d   = 1'b1;
                end else begin
                    quot_d = sign_q_q ? -q_q : q_q;
                    remo_d = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            b_zero_q <= 1'b0;
            quot_q   <= '0;
            remo_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            b_zero_q <= b_zero_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = remo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;

endmodule

// File: doc/sequential_div.md
Name: sequential_div

Overview:
- Multi-cycle signed divider: WIDTH-bit dividend A and divisor B produce a WIDTH-bit Quotient and a WIDTH-bit Remainder.
- It is the inverse operation of the sequential multiplier; both sit side by side in the ALU datapath.
- Algorithm is radix-2 restoring on operand magnitudes, one quotient bit per cycle, with a final sign correction.
- Start/done handshake, so the ALU sequencer can issue a divide and wait on done.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- A  input  WIDTH  signed dividend (two's complement); captured on accepted start.
- B  input  WIDTH  signed divisor (two's complement); captured on accepted start.
- Quotient  output  WIDTH  signed quotient, registered.
- Remainder  output  WIDTH  signed remainder, registered.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; Quotient/Remainder/div_by_zero valid in that cycle and held afterwards.
- div_by_zero  output  1  set with done when B == 0; cleared on next accepted start.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; Quotient=0, Remainder=0, busy=0, done=0, div_by_zero=0; iteration counter=0.
- Reset mid-operation aborts immediately with the same values; no done is produced.
- States: IDLE, ITER, FIX.
- IDLE: when start=1:
  - Latch sign_q = A[W-1]^B[W-1] and sign_r = A[W-1].
  - Load dividend magnitude |A| into the quotient shift register; load |B| into the divisor register (magnitudes are unsigned WIDTH bits, so |-2^(W-1)| = 2^(W-1)).
  - Clear the partial remainder (WIDTH+1 bits); clear div_by_zero; busy=1.
  - If B != 0: go to ITER, counter=0. If B == 0: go to FIX directly.
  - start=0 in IDLE: no change.
- ITER, one step per cycle, WIDTH cycles:
  - Shift {rem, q} left by 1.
  - trial = rem - divisor.
  - If trial >= 0: rem = trial, q[0] = 1; else q[0] = 0.
  - counter increments; after step WIDTH-1, go to FIX.
- FIX, one cycle:
  - Quotient = sign_q ? -q : q; Remainder = sign_r ? -rem : rem (truncation toward zero; remainder takes the dividend's sign).
  - done=1, busy=0, next state IDLE.
- Divide by zero, in FIX: Quotient = all ones, Remainder = A, div_by_zero = 1.
- Latency: start accepted at edge e0; done observed high after edge e0+WIDTH+1 (WIDTH+2 cycles total). Divide-by-zero: done after edge e0+1.
- done is high for exactly one cycle. Results hold until the next done or reset.
- start while busy is ignored (no queuing).
- Back-to-back: start asserted in the cycle done is high is accepted, because the state is already IDLE.
- Overflow: A = -2^(W-1), B = -1 gives Quotient = -2^(W-1) (wraps), Remainder = 0, no flag.
- A, B may change freely after the accepting edge.

Decomposition:
- Package div_pkg: state enum (IDLE, ITER, FIX), default WIDTH, counter width = $clog2(WIDTH)+1.
- Sub-module div_step, combinational: inputs rem, q, divisor; outputs next rem and next q for one restoring step.
- sequential_div instantiates one div_step and holds the FSM, registers, and sign fixup.

Test Plan:
- A=20, B=-3 -> done at cycle 34 after start; Quotient=-6 (0xFFFFFFFA), Remainder=2, div_by_zero=0.
- A=6776, B=88 -> Quotient=77, Remainder=0. A=-100, B=7 -> Quotient=-14, Remainder=-2. A=-90, B=-9 -> Quotient=10, Remainder=0.
- A=98765, B=0 -> done after 2 cycles; Quotient=0xFFFFFFFF, Remainder=98765, div_by_zero=1; next valid divide clears the flag.
- A=0x80000000, B=-1 -> Quotient=0x80000000, Remainder=0. A=0x80000000, B=1 -> Quotient=0x80000000, Remainder=0.
- Second start with A=1, B=1 pulsed at cycle 10 of a busy divide -> ignored, first result unchanged. Then start held high in the done cycle -> new op accepted, second done 34 cycles later.
- rst=1 at cycle 15 of an operation -> next cycle busy=0, Quotient=0, Remainder=0, no done pulse; a following divide of 77/-7 -> Quotient=-11, Remainder=0.
